mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for a 16x8 word/bit-writable register memory.
- Each requester issues READ, WORD WRITE or BIT WRITE over a valid/ready handshake.
- Grants are round-robin, with an optional lock for back-to-back bursts that is bounded by a starvation counter.
- Owns the storage through one sub-module and returns read data one cycle after acceptance.

Parameters:
- ADDR_W, 4, word address width; depth = 2**ADDR_W.
- DATA_W, 8, word width.
- BIT_W, $clog2(DATA_W), bit-index width (derived; do not override).
- LOCK_MAX, 8, maximum consecutive accepted transactions for one locked owner before forced release.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant)
- req0_op / req1_op  in  2  00 READ, 01 WRITE, 10 BITWR, 11 illegal
- req0_lock / req1_lock  in  1  hold ownership after this transaction
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  WRITE data
- req0_bit_idx / req1_bit_idx  in  BIT_W  BITWR bit position
- req0_bit_val / req1_bit_val  in  1  BITWR value
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse, no backpressure
- rsp0_rdata / rsp1_rdata  out  DATA_W  READ data; 0 for non-READ ops
- rsp0_err / rsp1_err  out  1  set for op 11

Behaviour:
- Reset values:
  - rsp*_valid = 0, rsp*_rdata = 0, rsp*_err = 0.
  - FSM state = IDLE, rr_last = 1 (requester 0 wins the first tie), lock_cnt = 0.
  - Memory contents are not reset and are undefined until written.
- Throughput and handshake:
  - At most one transaction accepted per cycle.
  - Transfer occurs when reqN_valid && reqN_ready.
  - reqN_ready is never high without reqN_valid.
  - reqN_ready for the non-granted requester is 0.
- FSM states:
  - IDLE:
    - Only one valid: grant it.
    - Both valid: grant the requester != rr_last.
    - On acceptance: rr_last <= granted id.
    - If lock=1: go to OWNn, lock_cnt <= 1.
  - OWN0 / OWN1:
    - Only the owner may be granted. The other requester waits even if the owner is idle.
    - Accepted with lock=1 and lock_cnt < LOCK_MAX-1: stay, lock_cnt++.
    - Accepted with lock=0: go to IDLE, lock_cnt <= 0.
    - Accepted with lock=1 and lock_cnt == LOCK_MAX-1: forced release to IDLE, lock_cnt <= 0. rr_last = owner, so the other requester wins the next tie.
    - Owner drops valid: stay in OWNn (lock persists until a lock=0 transaction or the limit).
- Memory effect at the acceptance edge:
  - WRITE: mem[addr] <= wdata.
  - BITWR: mem[addr][bit_idx] <= bit_val; other bits unchanged.
  - READ: rdata register <= mem[addr] (pre-edge contents).
  - Op 11: no memory change.
- Response timing:
  - rspN_valid pulses exactly one cycle, the cycle after acceptance, on the accepting requester only.
  - rspN_err = (op==11) on that pulse.
- Ordering:
  - A write followed by a read of the same address on the next accepted cycle returns the new data.
  - There are no same-cycle read/write conflicts (single port).
- Reset mid-operation:
  - Asynchronous assertion clears the FSM, lock and pending response immediately.
  - A response due on the next cycle is dropped.
  - Memory is untouched.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] op_e {OP_READ, OP_WRITE, OP_BITWR, OP_ILLEGAL}.
  - typedef enum logic [1:0] arb_state_e {ST_IDLE, ST_OWN0, ST_OWN1}.
  - Localparam LOCK_MAX_DEFAULT = 8.
- Sub-module mem_bank:
  - 2**ADDR_W x DATA_W array with word write enable and bit write enable (with index).
  - Registered read output with read enable.
  - No reset on the array.
- Top level holds the arbitration FSM, lock counter, request mux and response demux.

Test Plan:
- Req0 WRITE addr 3 = 0xA5, then req1 READ addr 3 -> rsp1_valid one cycle after acceptance, rsp1_rdata = 0xA5, rsp0 never pulses for the read.
- WRITE addr 7 = 0x00, then BITWR addr 7 idx 6 val 1, then BITWR idx 0 val 1, then READ addr 7 -> rdata = 0x41.
- Both valid for 4 consecutive cycles, no lock, all READs -> grants in order 0,1,0,1, one response per cycle to the matching requester.
- Req0 lock=1 for 10 consecutive WRITEs while req1 valid continuously, LOCK_MAX=8 -> req0 granted 8 times, then req1 granted, then req0 re-enters IDLE arbitration.
- Req1 op 11 addr 2 after WRITE addr 2 = 0x3C -> rsp1_err = 1, rsp1_rdata = 0; subsequent READ addr 2 returns 0x3C.
- rst_n low in the cycle after a READ is accepted -> no rsp pulse, state IDLE, rr_last = 1. After release, simultaneous valids grant req0 first, and memory still holds previously written data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port register-memory arbiter.
package mem_arb_pkg;

  // Request opcodes as they appear on the reqN_op pins.
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_BITWR   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  // Arbitration states: open round-robin, or locked to one owner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam int LOCK_MAX_DEFAULT = 8;

endpackage

// File: rtl/mem_bank.sv
// Word/bit-writable register array with a registered read port.
// The array itself carries no reset, so its contents are undefined until
// written. Resetting does not clear it.
module mem_bank #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int BIT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              word_we,
  input  logic              bit_we,
  input  logic [BIT_W-1:0]  bit_idx,
  input  logic              bit_val,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Word writes replace the whole entry; bit writes touch one bit only.
  always_ff @(posedge clk) begin
    if (word_we) begin
      mem[addr] <= wdata;
    end else if (bit_we) begin
      mem[addr][bit_idx] <= bit_val;
    end
  end

  // Read data captures the pre-edge contents and holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with bounded lock, sequencing a single
// port register memory and returning one-cycle response pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int BIT_W    = $clog2(DATA_W),
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [BIT_W-1:0]  req0_bit_idx,
  input  logic              req0_bit_val,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [BIT_W-1:0]  req1_bit_idx,
  input  logic              req1_bit_val,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_e        state;
  logic              rr_last;
  logic [CNT_W-1:0]  lock_cnt;

  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              sel;

  op_e               sel_op;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BIT_W-1:0]  sel_bit_idx;
  logic              sel_bit_val;

  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_read_q;
  logic [DATA_W-1:0] bank_rdata;

  // Grant decision: a locked owner excludes the other side even when idle;
  // otherwise a tie goes to whoever did not win last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt0 = rr_last;
          gnt1 = !rr_last;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
      ST_OWN0: gnt0 = req0_valid;
      ST_OWN1: gnt1 = req1_valid;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel        = gnt1;

  // Route the granted request's fields toward the memory.
  always_comb begin
    sel_op      = op_e'(sel ? req1_op : req0_op);
    sel_lock    = sel ? req1_lock : req0_lock;
    sel_addr    = sel ? req1_addr : req0_addr;
    sel_wdata   = sel ? req1_wdata : req0_wdata;
    sel_bit_idx = sel ? req1_bit_idx : req0_bit_idx;
    sel_bit_val = sel ? req1_bit_val : req0_bit_val;
  end

  mem_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BIT_W  (BIT_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (sel_addr),
    .wdata   (sel_wdata),
    .word_we (accept && (sel_op == OP_WRITE)),
    .bit_we  (accept && (sel_op == OP_BITWR)),
    .bit_idx (sel_bit_idx),
    .bit_val (sel_bit_val),
    .rd_en   (accept && (sel_op == OP_READ)),
    .rdata   (bank_rdata)
  );

  // Arbitration FSM, lock counter and the one-cycle response registers.
  // The lock counter counts accepted transactions of the current owner, so
  // the release happens on the LOCK_MAX-th transaction of a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_last     <= 1'b1;
      lock_cnt    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= {gnt1, gnt0};
      rsp_err_q   <= accept && (sel_op == OP_ILLEGAL);
      rsp_read_q  <= accept && (sel_op == OP_READ);
      if (accept) begin
        rr_last <= sel;
        if (!sel_lock) begin
          state    <= ST_IDLE;
          lock_cnt <= '0;
        end else if (state == ST_IDLE) begin
          state    <= sel ? ST_OWN1 : ST_OWN0;
          lock_cnt <= CNT_W'(1);
        end else if (lock_cnt >= LOCK_LAST) begin
          state    <= ST_IDLE;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;
  assign rsp0_rdata = (rsp_valid_q[0] && rsp_read_q) ? bank_rdata : '0;
  assign rsp1_rdata = (rsp_valid_q[1] && rsp_read_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver checks grants and queues
// expected responses, and a negedge monitor matches responses as they appear.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic       lock;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [2:0] bidx;
    logic       bval;
  } req_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req0_lock, req0_bit_val;
  logic       req1_valid, req1_ready, req1_lock, req1_bit_val;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic [2:0] req0_bit_idx, req1_bit_idx;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  req_t nop;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_lock    (req0_lock),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_bit_idx (req0_bit_idx),
    .req0_bit_val (req0_bit_val),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_lock    (req1_lock),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_bit_idx (req1_bit_idx),
    .req1_bit_val (req1_bit_val),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .rsp0_err     (rsp0_err),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .rsp1_err     (rsp1_err)
  );

  // Free-running clock and cycle counter used to time-stamp expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic req_t mkReq(input logic [1:0] op, input logic [3:0] addr,
                                 input logic [7:0] wdata, input logic [2:0] bidx,
                                 input logic bval, input logic lock);
    req_t r;
    r.valid = 1'b1;
    r.op    = op;
    r.lock  = lock;
    r.addr  = addr;
    r.wdata = wdata;
    r.bidx  = bidx;
    r.bval  = bval;
    return r;
  endfunction

  function automatic req_t rd(input logic [3:0] a);
    return mkReq(OP_READ, a, 8'h00, 3'd0, 1'b0, 1'b0);
  endfunction

  function automatic req_t wr(input logic [3:0] a, input logic [7:0] d, input logic lk);
    return mkReq(OP_WRITE, a, d, 3'd0, 1'b0, lk);
  endfunction

  function automatic req_t bw(input logic [3:0] a, input logic [2:0] i, input logic v);
    return mkReq(OP_BITWR, a, 8'h00, i, v, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic driveReqs(input req_t r0, input req_t r1);
    req0_valid   = r0.valid;  req0_op    = r0.op;    req0_lock    = r0.lock;
    req0_addr    = r0.addr;   req0_wdata = r0.wdata; req0_bit_idx = r0.bidx;
    req0_bit_val = r0.bval;
    req1_valid   = r1.valid;  req1_op    = r1.op;    req1_lock    = r1.lock;
    req1_addr    = r1.addr;   req1_wdata = r1.wdata; req1_bit_idx = r1.bidx;
    req1_bit_val = r1.bval;
  endtask

  // One cycle of stimulus: drive, check the grant, queue the expected response.
  task automatic applyStimulus(input req_t r0, input req_t r1, input logic [1:0] exp_gnt,
                               input logic [7:0] exp_data, input bit track);
    exp_t e;
    @(posedge clk);
    #2;
    driveReqs(r0, r1);
    #1;
    checkOutput("ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_gnt});
    if (track && exp_gnt != 2'b00) begin
      e.id   = exp_gnt[1];
      e.data = exp_data;
      e.err  = ((exp_gnt[1] ? r1.op : r0.op) == 2'b11);
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checkOutput("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, e.id ? 32'd2 : 32'd1);
      checkOutput("rsp_rdata", {24'd0, e.id ? rsp1_rdata : rsp0_rdata}, {24'd0, e.data});
      checkOutput("rsp_err", {31'd0, e.id ? rsp1_err : rsp0_err}, {31'd0, e.err});
    end else if (rsp0_valid || rsp1_valid) begin
      checkOutput("unexpected_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
  end

  initial begin
    nop = '{valid: 1'b0, op: 2'b00, lock: 1'b0, addr: 4'd0, wdata: 8'd0, bidx: 3'd0, bval: 1'b0};
    driveReqs(nop, nop);
    #1;
    checkOutput("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    checkOutput("reset_rsp0_rdata", {24'd0, rsp0_rdata}, 32'd0);
    checkOutput("reset_rsp1_rdata", {24'd0, rsp1_rdata}, 32'd0);
    checkOutput("reset_rsp_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
    checkOutput("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Write then cross-requester read of the same word.
    applyStimulus(wr(4'd3, 8'hA5, 1'b0), nop, 2'b01, 8'h00, 1);
    applyStimulus(nop, rd(4'd3), 2'b10, 8'hA5, 1);
    applyStimulus(nop, wr(4'd4, 8'h5A, 1'b0), 2'b10, 8'h00, 1);

    // Contended reads alternate 0,1,0,1.
    applyStimulus(rd(4'd3), rd(4'd4), 2'b01, 8'hA5, 1);
    applyStimulus(rd(4'd3), rd(4'd4), 2'b10, 8'h5A, 1);
    applyStimulus(rd(4'd3), rd(4'd4), 2'b01, 8'hA5, 1);
    applyStimulus(rd(4'd3), rd(4'd4), 2'b10, 8'h5A, 1);

    // Bit writes build 0x41 in word 7.
    applyStimulus(wr(4'd7, 8'h00, 1'b0), nop, 2'b01, 8'h00, 1);
    applyStimulus(bw(4'd7, 3'd6, 1'b1), nop, 2'b01, 8'h00, 1);
    applyStimulus(bw(4'd7, 3'd0, 1'b1), nop, 2'b01, 8'h00, 1);
    applyStimulus(rd(4'd7), nop, 2'b01, 8'h41, 1);

    // Illegal op reports an error and leaves memory alone.
    applyStimulus(wr(4'd2, 8'h3C, 1'b0), nop, 2'b01, 8'h00, 1);
    applyStimulus(nop, mkReq(OP_ILLEGAL, 4'd2, 8'hFF, 3'd1, 1'b1, 1'b0), 2'b10, 8'h00, 1);
    applyStimulus(nop, rd(4'd2), 2'b10, 8'h3C, 1);

    // Locked burst is cut off after eight transactions while req1 waits.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(wr(4'(8 + i), 8'(8'h10 + i), 1'b1), rd(4'd7), 2'b01, 8'h00, 1);
    end
    applyStimulus(wr(4'd8, 8'h18, 1'b1), rd(4'd7), 2'b10, 8'h41, 1);
    applyStimulus(wr(4'd8, 8'h18, 1'b1), nop, 2'b01, 8'h00, 1);
    applyStimulus(wr(4'd9, 8'h19, 1'b1), nop, 2'b01, 8'h00, 1);
    applyStimulus(nop, rd(4'd7), 2'b00, 8'h00, 1);
    applyStimulus(wr(4'd10, 8'h77, 1'b0), rd(4'd7), 2'b01, 8'h00, 1);
    applyStimulus(nop, rd(4'd7), 2'b10, 8'h41, 1);
    applyStimulus(rd(4'd15), nop, 2'b01, 8'h17, 1);
    applyStimulus(rd(4'd10), nop, 2'b01, 8'h77, 1);
    applyStimulus(rd(4'd9), nop, 2'b01, 8'h19, 1);

    // Reset right after a read is accepted drops its response.
    applyStimulus(rd(4'd4), nop, 2'b01, 8'h00, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    driveReqs(nop, nop);
    #1;
    checkOutput("midrst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    checkOutput("midrst_rsp0_rdata", {24'd0, rsp0_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(rd(4'd3), rd(4'd4), 2'b01, 8'hA5, 1);
    applyStimulus(nop, rd(4'd4), 2'b10, 8'h5A, 1);
    applyStimulus(nop, nop, 2'b00, 8'h00, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
